// File: rtl/bpd_request_tracker.sv
// bpd_request_tracker
//   Core-side initiator for the branch-predictor harness. Each branch PC
//   accepted from fetch is sent to the harness as a prediction request. The
//   harness answers one cycle later, and that answer goes back to fetch
//   together with the tracking-queue slot it occupies. The prediction is kept
//   in an in-order queue until the branch resolves. Resolution drives the
//   harness update channel and the mispredict statistics.
//
// Ports
//   clock, reset           : clock; asynchronous active-low reset
//   fetch_valid/fetch_pc   : branch offered by fetch
//   fetch_ready            : tracker takes the branch this cycle
//   req_valid/req_pc       : harness prediction request (combinational)
//   req_taken              : harness prediction, valid the cycle after req_valid
//   pred_valid/pred_taken  : prediction returned to fetch
//   pred_tag               : queue slot holding that prediction
//   resolve_valid/_taken   : oldest outstanding branch resolved, actual direction
//   flush                  : drop every outstanding prediction
//   update_valid/_pc/_taken: harness training strobe (registered)
//   mispredict             : qualifies update_valid, prediction != actual
//   resolve_err            : resolve seen with an empty queue
//   branch_count           : resolved branches, saturating
//   mispredict_count       : mispredicted branches, saturating
//
// Handshake: a fetch transfer happens in every cycle where fetch_valid and
// fetch_ready are both high. fetch_ready does not depend on fetch_valid.
// fetch_pc must stay stable while fetch_valid is high and fetch_ready is low.
// The request channel has no back-pressure, so req_valid is exactly the
// transfer. The update channel is a one-cycle strobe that needs no
// acknowledgement.

module bpd_request_tracker #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [PC_W-1:0]          fetch_pc,
  output logic                     fetch_ready,
  output logic                     req_valid,
  output logic [PC_W-1:0]          req_pc,
  input  logic                     req_taken,
  output logic                     pred_valid,
  output logic                     pred_taken,
  output logic [$clog2(DEPTH)-1:0] pred_tag,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     update_valid,
  output logic [PC_W-1:0]          update_pc,
  output logic                     update_taken,
  output logic                     mispredict,
  output logic                     resolve_err,
  output logic [CNT_W-1:0]         branch_count,
  output logic [CNT_W-1:0]         mispredict_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_OCC = (AW+1)'(DEPTH);

  // Low in the first cycle after reset releases, so fetch_ready and req_pc
  // stay 0 until the first clock edge after release.
  logic            active;

  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW:0]     count;
  logic            s1_valid;
  logic [PC_W-1:0] s1_pc;

  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;

  logic [AW:0]     occupancy;
  logic            do_write;
  logic            do_pop;
  logic            head_mismatch;

  always_comb begin
    occupancy     = '0;
    fetch_ready   = 1'b0;
    req_valid     = 1'b0;
    req_pc        = '0;
    do_write      = 1'b0;
    do_pop        = 1'b0;
    pred_valid    = 1'b0;
    pred_taken    = 1'b0;
    pred_tag      = '0;
    head_mismatch = 1'b0;

    // Slots are reserved at acceptance. The entry still in s1 counts here,
    // so the queue can never overflow.
    occupancy   = count + {{AW{1'b0}}, s1_valid};
    fetch_ready = active && (occupancy < DEPTH_OCC) && !flush;
    req_valid   = fetch_valid && fetch_ready;
    req_pc      = active ? fetch_pc : '0;

    // During flush, the prediction in s1 is discarded rather than written.
    do_write    = s1_valid && !flush;
    // count covers written entries only. A resolve that arrives while the
    // first entry is still in s1 finds the queue empty.
    do_pop      = resolve_valid && (count != '0);

    pred_valid  = s1_valid && !flush;
    pred_taken  = s1_valid && req_taken;
    pred_tag    = tail;

    head_mismatch = taken_mem[head] != resolve_taken;
  end

  // Queue storage holds no reset-dependent state.
  always_ff @(posedge clock) begin
    if (do_write) begin
      pc_mem[tail]    <= s1_pc;
      taken_mem[tail] <= req_taken;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active           <= 1'b0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      s1_valid         <= 1'b0;
      s1_pc            <= '0;
      update_valid     <= 1'b0;
      update_pc        <= '0;
      update_taken     <= 1'b0;
      mispredict       <= 1'b0;
      resolve_err      <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      active   <= 1'b1;

      // fetch_ready is already low during flush, so this also clears s1.
      s1_valid <= req_valid;
      if (req_valid) begin
        s1_pc <= fetch_pc;
      end

      if (do_write) begin
        tail <= tail + AW'(1);
      end

      // A pop in the flush cycle is still reported. The flush then makes the
      // queue empty at the current tail.
      if (flush) begin
        head  <= tail;
        count <= '0;
      end else begin
        if (do_pop) begin
          head <= head + AW'(1);
        end
        case ({do_write, do_pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end

      update_valid <= do_pop;
      update_pc    <= do_pop ? pc_mem[head] : '0;
      update_taken <= do_pop && resolve_taken;
      mispredict   <= do_pop && head_mismatch;
      resolve_err  <= resolve_valid && (count == '0);

      if (do_pop) begin
        if (branch_count != {CNT_W{1'b1}}) begin
          branch_count <= branch_count + CNT_W'(1);
        end
        if (head_mismatch && (mispredict_count != {CNT_W{1'b1}})) begin
          mispredict_count <= mispredict_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bpd_request_tracker.sv
// Bench for bpd_request_tracker. A queue-based model of outstanding
// predictions predicts every output cycle by cycle. Directed scenarios add
// literal expectations, and a randomized phase follows them.

module tb_bpd_request_tracker;

  localparam int DEPTH = 8;
  localparam int PC_W  = 64;
  localparam int CNT_W = 8;
  localparam int AW    = 3;
  localparam int CMAX  = 255;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT ----------------
  logic             fetch_valid;
  logic [PC_W-1:0]  fetch_pc;
  logic             fetch_ready;
  logic             req_valid;
  logic [PC_W-1:0]  req_pc;
  logic             req_taken;
  logic             pred_valid;
  logic             pred_taken;
  logic [AW-1:0]    pred_tag;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             flush;
  logic             update_valid;
  logic [PC_W-1:0]  update_pc;
  logic             update_taken;
  logic             mispredict;
  logic             resolve_err;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  bpd_request_tracker #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .fetch_ready      (fetch_ready),
    .req_valid        (req_valid),
    .req_pc           (req_pc),
    .req_taken        (req_taken),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .pred_tag         (pred_tag),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .flush            (flush),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .mispredict       (mispredict),
    .resolve_err      (resolve_err),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // ---------------- scoreboard state ----------------
  int n_checks;
  int n_fail;

  // Each entry is {pc, predicted_taken}, oldest first.
  logic [PC_W:0]   exp_q[$];
  logic [PC_W:0]   popped;
  bit              m_active;
  bit              m_s1_valid;
  logic [PC_W-1:0] m_s1_pc;
  int              m_writes;
  bit              m_upd_valid;
  logic [PC_W-1:0] m_upd_pc;
  bit              m_upd_taken;
  bit              m_mis;
  bit              m_err;
  int              m_branch;
  int              m_misp;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_active    = 0;
    m_s1_valid  = 0;
    m_s1_pc     = '0;
    m_writes    = 0;
    m_upd_valid = 0;
    m_upd_pc    = '0;
    m_upd_taken = 0;
    m_mis       = 0;
    m_err       = 0;
    m_branch    = 0;
    m_misp      = 0;
  endfunction

  function automatic logic any_output_set();
    return fetch_ready | req_valid | (|req_pc) | pred_valid | pred_taken |
           (|pred_tag) | update_valid | (|update_pc) | update_taken |
           mispredict | resolve_err | (|branch_count) | (|mispredict_count);
  endfunction

  // ---------------- compare process ----------------
  // The bench drives inputs 1 time unit after each rising edge. This process
  // checks the outputs on the falling edge and then advances the model by one
  // clock.
  always @(negedge clock) begin
    bit exp_ready, exp_req, pop;
    if (!reset) begin
      check("reset_outputs_zero", any_output_set(), 0);
      model_reset();
    end else begin
      exp_ready = m_active && ((exp_q.size() + int'(m_s1_valid)) < DEPTH) && !flush;
      exp_req   = fetch_valid && exp_ready;
      check("fetch_ready", fetch_ready, exp_ready);
      check("req_valid", req_valid, exp_req);
      if (exp_req) check("req_pc", req_pc, fetch_pc);
      check("pred_valid", pred_valid, m_s1_valid && !flush);
      if (m_s1_valid && !flush) begin
        check("pred_taken", pred_taken, req_taken);
        check("pred_tag", pred_tag, m_writes % DEPTH);
      end
      check("update_valid", update_valid, m_upd_valid);
      check("update_pc", update_pc, m_upd_pc);
      check("update_taken", update_taken, m_upd_taken);
      check("mispredict", mispredict, m_mis);
      check("resolve_err", resolve_err, m_err);
      check("branch_count", branch_count, m_branch);
      check("mispredict_count", mispredict_count, m_misp);

      // Next state: resolve, then s1 write, then flush.
      pop   = resolve_valid && (exp_q.size() > 0);
      m_err = resolve_valid && (exp_q.size() == 0);
      if (pop) begin
        popped      = exp_q.pop_front();
        m_upd_valid = 1;
        m_upd_pc    = popped[PC_W:1];
        m_upd_taken = resolve_taken;
        m_mis       = popped[0] != resolve_taken;
        if (m_branch < CMAX) m_branch++;
        if (m_mis && m_misp < CMAX) m_misp++;
      end else begin
        m_upd_valid = 0;
        m_upd_pc    = '0;
        m_upd_taken = 0;
        m_mis       = 0;
      end
      if (m_s1_valid && !flush) begin
        exp_q.push_back({m_s1_pc, req_taken});
        m_writes++;
      end
      if (flush) begin
        exp_q.delete();
        m_s1_valid = 0;
      end else begin
        m_s1_valid = exp_req;
        if (exp_req) m_s1_pc = fetch_pc;
      end
      m_active = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_valid   = 0;
    fetch_pc      = '0;
    req_taken     = 0;
    resolve_valid = 0;
    resolve_taken = 0;
    flush         = 0;
  endtask

  // Asserts reset right away, which may fall in the middle of a cycle. Then
  // releases it and leaves the DUT in its first active cycle.
  task automatic do_reset();
    reset = 0;
    clear_inputs();
    #1;
    check("async_reset_immediate", any_output_set(), 0);
    tick();
    tick();
    reset = 1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    reset = 0;
    clear_inputs();
    do_reset();

    // Single branch, predicted taken, resolves not-taken.
    fetch_valid = 1; fetch_pc = 64'h1000;
    @(negedge clock);
    check("single_fetch_ready", fetch_ready, 1);
    check("single_req_valid", req_valid, 1);
    tick();
    fetch_valid = 0; req_taken = 1;
    @(negedge clock);
    check("single_pred_valid", pred_valid, 1);
    check("single_pred_taken", pred_taken, 1);
    check("single_pred_tag", pred_tag, 0);
    tick();
    req_taken = 0; resolve_valid = 1; resolve_taken = 0;
    tick();
    resolve_valid = 0;
    @(negedge clock);
    check("single_update_valid", update_valid, 1);
    check("single_update_pc", update_pc, 64'h1000);
    check("single_update_taken", update_taken, 0);
    check("single_mispredict", mispredict, 1);
    check("single_mispredict_count", mispredict_count, 1);
    check("single_branch_count", branch_count, 1);
    tick();

    // Fill to DEPTH, release one slot, then watch the tag wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      fetch_valid = 1; fetch_pc = 64'h2000 + 64'(i * 4); req_taken = 1'($urandom);
      @(negedge clock);
      check("fill_ready", fetch_ready, 1);
      tick();
    end
    fetch_pc = 64'h2020; req_taken = 1'($urandom);
    resolve_valid = 1; resolve_taken = 1'($urandom);
    @(negedge clock);
    check("fill_full_not_ready", fetch_ready, 0);
    tick();
    resolve_valid = 0;
    @(negedge clock);
    check("fill_ready_after_resolve", fetch_ready, 1);
    tick();
    fetch_valid = 0; req_taken = 1'($urandom);
    @(negedge clock);
    check("fill_tag_wrap_valid", pred_valid, 1);
    check("fill_tag_wrap", pred_tag, 0);
    tick();

    // Streaming: fetch every cycle, 100 resolves once the first entry is in.
    do_reset();
    for (int c = 0; c < 102; c++) begin
      fetch_valid = 1; fetch_pc = 64'h4000 + 64'(c * 4);
      req_taken = 1'($urandom);
      resolve_valid = (c >= 2); resolve_taken = 1'($urandom);
      tick();
    end
    clear_inputs();
    @(negedge clock);
    check("stream_branch_count", branch_count, 100);
    tick();

    // Flush with five outstanding and a same-cycle resolve.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fetch_valid = 1; fetch_pc = 64'h3000 + 64'(i * 4); req_taken = 1'($urandom);
      tick();
    end
    fetch_valid = 0; req_taken = 1'($urandom);
    tick();
    flush = 1; resolve_valid = 1; resolve_taken = 1;
    tick();
    flush = 0; resolve_valid = 0;
    fetch_valid = 1; fetch_pc = 64'h5000;
    @(negedge clock);
    check("flush_update_valid", update_valid, 1);
    check("flush_update_pc", update_pc, 64'h3000);
    check("flush_ready_after", fetch_ready, 1);
    tick();
    fetch_valid = 0;
    @(negedge clock);
    check("flush_next_tag", pred_tag, 5);
    tick();

    // Resolve against an empty queue.
    do_reset();
    resolve_valid = 1; resolve_taken = 1;
    tick();
    resolve_valid = 0;
    @(negedge clock);
    check("empty_no_update", update_valid, 0);
    check("empty_resolve_err", resolve_err, 1);
    check("empty_branch_count", branch_count, 0);
    tick();
    @(negedge clock);
    check("empty_err_one_cycle", resolve_err, 0);
    tick();

    // Async reset with three outstanding and an update in flight.
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1; fetch_pc = 64'h6000 + 64'(i * 4); req_taken = 1'($urandom);
      tick();
    end
    fetch_valid = 0;
    tick();
    resolve_valid = 1; resolve_taken = 1'($urandom);
    tick();
    resolve_valid = 0;
    check("midreset_update_in_flight", update_valid, 1);
    do_reset();
    for (int i = 0; i < 3; i++) tick();

    // Randomized traffic. It is long enough to saturate the 8-bit counters.
    for (int c = 0; c < 1500; c++) begin
      fetch_valid   = ($urandom_range(0, 99) < 60);
      fetch_pc      = {$urandom, $urandom};
      req_taken     = 1'($urandom_range(0, 1));
      resolve_valid = ($urandom_range(0, 99) < 60);
      resolve_taken = 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 99) < 3);
      tick();
    end
    clear_inputs();
    @(negedge clock);
    check("random_branch_count_saturated", branch_count, 8'hFF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
